// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg
// Shared types and constants for the APB2AXI converter.
//   completion_entry_t : one entry pushed toward the completion queue
//   AXI_RESP_*         : AXI response encodings. Numeric order matches severity.
//   worse_resp()       : picks the more severe of two AXI responses
package apb2axi_pkg;

  localparam int TAG_NUM       = 16;
  localparam int TAG_W         = $clog2(TAG_NUM);
  localparam int AXI_DATA_W    = 64;
  localparam int MAX_BEATS_NUM = 16;
  // An AXI len of 255 means 256 beats, so 9 bits are needed.
  localparam int NUM_BEATS_W   = 9;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                   is_write;
    logic [TAG_W-1:0]       tag;
    logic [1:0]             resp;
    logic                   error;
    logic [NUM_BEATS_W-1:0] num_beats;
  } completion_entry_t;

  localparam int COMPLETION_W = $bits(completion_entry_t);

  function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb2axi_tag_tracker.sv
// apb2axi_tag_tracker
// Per-tag bookkeeping for outstanding bursts.
// Each tag stores:
//   - expected len
//   - beat count
//   - worst response seen
//   - sticky overflow flag
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   ld_en/ld_tag/ld_len
//                     : load the expected len and clear the other fields
//   upd_en/upd_tag/upd_cnt/upd_resp/upd_ovf
//                     : overwrite count, response and overflow for one tag.
//                       A clear is an update with zeros.
//   r_tag -> r_len/r_cnt/r_resp/r_ovf
//                     : combinational read for the R channel
//   b_tag -> b_len    : combinational read for the B channel
module apb2axi_tag_tracker #(
  parameter  int TAG_NUM = 16,
  localparam int TAG_W   = $clog2(TAG_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic [7:0]       ld_len,
  input  logic             upd_en,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [4:0]       upd_cnt,
  input  logic [1:0]       upd_resp,
  input  logic             upd_ovf,
  input  logic [TAG_W-1:0] r_tag,
  output logic [7:0]       r_len,
  output logic [4:0]       r_cnt,
  output logic [1:0]       r_resp,
  output logic             r_ovf,
  input  logic [TAG_W-1:0] b_tag,
  output logic [7:0]       b_len
);

  logic [7:0] len_q  [TAG_NUM];
  logic [4:0] cnt_q  [TAG_NUM];
  logic [1:0] resp_q [TAG_NUM];
  logic       ovf_q  [TAG_NUM];

  // The load is written after the update so it wins on a tag collision.
  // A collision is illegal and is flagged by an assertion in the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        len_q[i]  <= '0;
        cnt_q[i]  <= '0;
        resp_q[i] <= '0;
        ovf_q[i]  <= 1'b0;
      end
    end else begin
      if (upd_en) begin
        cnt_q[upd_tag]  <= upd_cnt;
        resp_q[upd_tag] <= upd_resp;
        ovf_q[upd_tag]  <= upd_ovf;
      end
      if (ld_en) begin
        len_q[ld_tag]  <= ld_len;
        cnt_q[ld_tag]  <= '0;
        resp_q[ld_tag] <= '0;
        ovf_q[ld_tag]  <= 1'b0;
      end
    end
  end

  assign r_len  = len_q[r_tag];
  assign r_cnt  = cnt_q[r_tag];
  assign r_resp = resp_q[r_tag];
  assign r_ovf  = ovf_q[r_tag];
  assign b_len  = len_q[b_tag];

endmodule

// File: rtl/apb2axi_rsp_collector.sv
// apb2axi_rsp_collector
// Collects AXI R and B responses.
//   - Read beats pass straight through to the read-data buffer.
//   - At each burst end, one completion_entry_t is emitted.
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   exp_wr_en/exp_tag/exp_len : issue logic loads the expected AXI len for a tag
//   rvalid/rlast/rid/rdata/rresp/rready
//                             : AXI R channel
//   bvalid/bid/bresp/bready   : AXI B channel
//   rd_valid/rd_ready/rd_tag/rd_beat/rd_data
//                             : read beats toward the data buffer
//   cpl_valid/cpl_ready/cpl_entry
//                             : completion entries toward the completion queue
module apb2axi_rsp_collector
  import apb2axi_pkg::*;
#(
  parameter  int TAG_NUM       = apb2axi_pkg::TAG_NUM,
  parameter  int AXI_DATA_W    = apb2axi_pkg::AXI_DATA_W,
  parameter  int MAX_BEATS_NUM = apb2axi_pkg::MAX_BEATS_NUM,
  localparam int TAG_W         = $clog2(TAG_NUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exp_wr_en,
  input  logic [TAG_W-1:0]        exp_tag,
  input  logic [7:0]              exp_len,
  input  logic                    rvalid,
  input  logic                    rlast,
  input  logic [TAG_W-1:0]        rid,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic [1:0]              rresp,
  output logic                    rready,
  input  logic                    bvalid,
  input  logic [TAG_W-1:0]        bid,
  input  logic [1:0]              bresp,
  output logic                    bready,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [3:0]              rd_beat,
  output logic [AXI_DATA_W-1:0]   rd_data,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic [COMPLETION_W-1:0] cpl_entry
);

  logic [7:0]        t_len, t_blen;
  logic [4:0]        t_cnt;
  logic [1:0]        t_resp;
  logic              t_ovf;
  logic              slot_free, ovf_hit, r_hs, r_last_hs, b_hs;
  logic [1:0]        merged_resp;
  logic              upd_en, upd_ovf;
  logic [4:0]        upd_cnt;
  logic [1:0]        upd_resp;
  completion_entry_t r_entry, b_entry, cpl_q;

  apb2axi_tag_tracker #(.TAG_NUM(TAG_NUM)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .ld_en    (exp_wr_en),
    .ld_tag   (exp_tag),
    .ld_len   (exp_len),
    .upd_en   (upd_en),
    .upd_tag  (rid),
    .upd_cnt  (upd_cnt),
    .upd_resp (upd_resp),
    .upd_ovf  (upd_ovf),
    .r_tag    (rid),
    .r_len    (t_len),
    .r_cnt    (t_cnt),
    .r_resp   (t_resp),
    .r_ovf    (t_ovf),
    .b_tag    (bid),
    .b_len    (t_blen)
  );

  // A last beat needs the completion slot. Non-last beats only need the data buffer.
  assign slot_free = !cpl_valid || cpl_ready;
  assign ovf_hit   = (t_cnt == 5'(MAX_BEATS_NUM));
  assign rready    = rd_ready && (!rlast || slot_free);
  assign rd_valid  = rvalid && (!rlast || slot_free) && !ovf_hit;
  assign rd_tag    = rid;
  assign rd_beat   = t_cnt[3:0];
  assign rd_data   = rdata;
  assign r_hs      = rvalid && rready;
  assign r_last_hs = r_hs && rlast;

  // B yields to an R last beat competing for the same completion slot.
  assign bready = slot_free && !r_last_hs;
  assign b_hs   = bvalid && bready;

  assign merged_resp = worse_resp(t_resp, rresp);

  // Beats past the maximum are consumed but not counted; the count saturates.
  // A last beat retires the tag's counters in the same cycle.
  always_comb begin
    upd_en   = r_hs;
    upd_cnt  = ovf_hit ? t_cnt : t_cnt + 5'd1;
    upd_resp = merged_resp;
    upd_ovf  = t_ovf | ovf_hit;
    if (r_last_hs) begin
      upd_cnt  = '0;
      upd_resp = '0;
      upd_ovf  = 1'b0;
    end
  end

  always_comb begin
    r_entry           = '0;
    r_entry.is_write  = 1'b0;
    r_entry.tag       = rid;
    r_entry.resp      = merged_resp;
    r_entry.num_beats = NUM_BEATS_W'(t_cnt) + NUM_BEATS_W'(1);
    r_entry.error     = merged_resp[1] | t_ovf | ({3'b000, t_cnt} != t_len);
    b_entry           = '0;
    b_entry.is_write  = 1'b1;
    b_entry.tag       = bid;
    b_entry.resp      = bresp;
    b_entry.error     = bresp[1];
    b_entry.num_beats = NUM_BEATS_W'(t_blen) + NUM_BEATS_W'(1);
  end

  // Single completion register.
  // Loads only happen when the slot is free, so the entry holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_valid <= 1'b0;
      cpl_q     <= '0;
    end else if (r_last_hs) begin
      cpl_valid <= 1'b1;
      cpl_q     <= r_entry;
    end else if (b_hs) begin
      cpl_valid <= 1'b1;
      cpl_q     <= b_entry;
    end else if (cpl_ready) begin
      cpl_valid <= 1'b0;
    end
  end

  assign cpl_entry = cpl_q;

  // Loading a tag while its response traffic completes would corrupt its counters.
  assert property (@(posedge clk) disable iff (rst)
    exp_wr_en |-> !((r_hs && rid == exp_tag) || (b_hs && bid == exp_tag)));

endmodule

// File: tb/tb_apb2axi_rsp_collector.sv
// Directed bench for apb2axi_rsp_collector with hand-computed completion entries.
module tb_apb2axi_rsp_collector;
  import apb2axi_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    exp_wr_en;
  logic [3:0]              exp_tag;
  logic [7:0]              exp_len;
  logic                    rvalid, rlast;
  logic [3:0]              rid;
  logic [63:0]             rdata;
  logic [1:0]              rresp;
  logic                    rready;
  logic                    bvalid;
  logic [3:0]              bid;
  logic [1:0]              bresp;
  logic                    bready;
  logic                    rd_valid, rd_ready;
  logic [3:0]              rd_tag, rd_beat;
  logic [63:0]             rd_data;
  logic                    cpl_valid, cpl_ready;
  logic [COMPLETION_W-1:0] cpl_entry;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  apb2axi_rsp_collector dut (
    .clk(clk), .rst(rst),
    .exp_wr_en(exp_wr_en), .exp_tag(exp_tag), .exp_len(exp_len),
    .rvalid(rvalid), .rlast(rlast), .rid(rid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_tag(rd_tag), .rd_beat(rd_beat), .rd_data(rd_data),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_entry(cpl_entry)
  );

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkCpl(input logic iw, input logic [3:0] tag,
                                        input logic [1:0] resp, input logic err, input int nb);
    completion_entry_t e;
    e.is_write  = iw;
    e.tag       = tag;
    e.resp      = resp;
    e.error     = err;
    e.num_beats = 9'(nb);
    return 64'(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadTag(input logic [3:0] tag, input logic [7:0] len);
    exp_wr_en = 1'b1;
    exp_tag   = tag;
    exp_len   = len;
    tick();
    exp_wr_en = 1'b0;
  endtask

  // Drives one R beat for one cycle.
  // Checks the pass-through outputs before the clock edge.
  task automatic applyStimulus(input string name, input logic [3:0] tag, input logic [1:0] resp,
                               input logic last, input logic expValid, input logic [3:0] expBeat);
    rvalid = 1'b1;
    rlast  = last;
    rid    = tag;
    rresp  = resp;
    rdata  = {48'hC0FFEE_0000, 8'(tag), 4'h0, expBeat};
    #1;
    checkOutput({name, ".rready"}, 64'(rready), 64'd1);
    checkOutput({name, ".rd_valid"}, 64'(rd_valid), 64'(expValid));
    if (expValid) begin
      checkOutput({name, ".rd_beat"}, 64'(rd_beat), 64'(expBeat));
      checkOutput({name, ".rd_tag"}, 64'(rd_tag), 64'(tag));
      checkOutput({name, ".rd_data"}, rd_data, {48'hC0FFEE_0000, 8'(tag), 4'h0, expBeat});
    end
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic expectCpl(input string name, input logic [63:0] exp);
    checkOutput({name, ".cpl_valid"}, 64'(cpl_valid), 64'd1);
    checkOutput({name, ".cpl_entry"}, 64'(cpl_entry), exp);
  endtask

  initial begin
    #200000;
    testsFailed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; exp_wr_en = 1'b0; exp_tag = '0; exp_len = '0;
    rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0; rresp = '0;
    bvalid = 1'b0; bid = '0; bresp = '0; rd_ready = 1'b0; cpl_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("reset.cpl_valid", 64'(cpl_valid), 64'd0);
    checkOutput("reset.cpl_entry", 64'(cpl_entry), 64'd0);
    checkOutput("reset.rready", 64'(rready), 64'd0);
    checkOutput("reset.rd_valid", 64'(rd_valid), 64'd0);
    rd_ready = 1'b1; cpl_ready = 1'b1;
    tick();

    // Test 1: tag 3, four beats, all OKAY.
    loadTag(4'd3, 8'd3);
    for (int i = 0; i < 4; i++)
      applyStimulus("t1.beat", 4'd3, AXI_RESP_OKAY, (i == 3), 1'b1, 4'(i));
    expectCpl("t1", mkCpl(1'b0, 4'd3, 2'b00, 1'b0, 4));
    tick();
    checkOutput("t1.drain", 64'(cpl_valid), 64'd0);

    // Test 2: tag 5, OKAY then SLVERR.
    loadTag(4'd5, 8'd1);
    applyStimulus("t2.b0", 4'd5, AXI_RESP_OKAY, 1'b0, 1'b1, 4'd0);
    applyStimulus("t2.b1", 4'd5, AXI_RESP_SLVERR, 1'b1, 1'b1, 4'd1);
    expectCpl("t2", mkCpl(1'b0, 4'd5, 2'b10, 1'b1, 2));
    tick();

    // Test 3: tag 2, early rlast on the 2nd of 4 beats.
    loadTag(4'd2, 8'd3);
    applyStimulus("t3.b0", 4'd2, AXI_RESP_OKAY, 1'b0, 1'b1, 4'd0);
    applyStimulus("t3.b1", 4'd2, AXI_RESP_EXOKAY, 1'b1, 1'b1, 4'd1);
    expectCpl("t3", mkCpl(1'b0, 4'd2, 2'b01, 1'b1, 2));
    tick();

    // Test 4: B write completion with SLVERR on tag 9.
    loadTag(4'd9, 8'd3);
    bvalid = 1'b1; bid = 4'd9; bresp = AXI_RESP_SLVERR;
    #1;
    checkOutput("t4.bready", 64'(bready), 64'd1);
    tick();
    bvalid = 1'b0;
    expectCpl("t4", mkCpl(1'b1, 4'd9, 2'b10, 1'b1, 4));
    tick();
    checkOutput("t4.drain", 64'(cpl_valid), 64'd0);

    // Test 5: backpressure, with R last beats competing against B for the slot.
    loadTag(4'd1, 8'd0);
    loadTag(4'd2, 8'd0);
    loadTag(4'd7, 8'd15);
    cpl_ready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rresp = AXI_RESP_OKAY; rdata = 64'h11;
    bvalid = 1'b1; bid = 4'd7; bresp = AXI_RESP_OKAY;
    #1;
    checkOutput("t5.c0.rready", 64'(rready), 64'd1);
    checkOutput("t5.c0.bready", 64'(bready), 64'd0);
    tick();
    rid = 4'd2; rdata = 64'h22;
    #1;
    expectCpl("t5.c1", mkCpl(1'b0, 4'd1, 2'b00, 1'b0, 1));
    checkOutput("t5.c1.rready", 64'(rready), 64'd0);
    checkOutput("t5.c1.bready", 64'(bready), 64'd0);
    checkOutput("t5.c1.rd_valid", 64'(rd_valid), 64'd0);
    tick();
    expectCpl("t5.c2.stable", mkCpl(1'b0, 4'd1, 2'b00, 1'b0, 1));
    checkOutput("t5.c2.rready", 64'(rready), 64'd0);
    cpl_ready = 1'b1;
    #1;
    checkOutput("t5.c2.rready_rel", 64'(rready), 64'd1);
    checkOutput("t5.c2.bready_rel", 64'(bready), 64'd0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    expectCpl("t5.c3", mkCpl(1'b0, 4'd2, 2'b00, 1'b0, 1));
    checkOutput("t5.c3.bready", 64'(bready), 64'd1);
    tick();
    bvalid = 1'b0;
    expectCpl("t5.c4", mkCpl(1'b1, 4'd7, 2'b00, 1'b0, 16));
    tick();
    checkOutput("t5.drain", 64'(cpl_valid), 64'd0);

    // Test 6: tag 4 overflows.
    // The 17th beat and the final rlast are dropped.
    loadTag(4'd4, 8'd15);
    for (int i = 0; i < 16; i++)
      applyStimulus("t6.beat", 4'd4, AXI_RESP_OKAY, 1'b0, 1'b1, 4'(i));
    applyStimulus("t6.b16", 4'd4, AXI_RESP_OKAY, 1'b0, 1'b0, 4'd0);
    applyStimulus("t6.last", 4'd4, AXI_RESP_OKAY, 1'b1, 1'b0, 4'd0);
    expectCpl("t6", mkCpl(1'b0, 4'd4, 2'b00, 1'b1, 17));
    tick();

    // Test 7: reset during a tag-6 burst, with a completion pending.
    cpl_ready = 1'b0;
    applyStimulus("t7.pend", 4'd1, AXI_RESP_OKAY, 1'b1, 1'b1, 4'd0);
    loadTag(4'd6, 8'd3);
    applyStimulus("t7.b0", 4'd6, AXI_RESP_OKAY, 1'b0, 1'b1, 4'd0);
    applyStimulus("t7.b1", 4'd6, AXI_RESP_OKAY, 1'b0, 1'b1, 4'd1);
    checkOutput("t7.pending", 64'(cpl_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t7.rst.cpl_valid", 64'(cpl_valid), 64'd0);
    checkOutput("t7.rst.cpl_entry", 64'(cpl_entry), 64'd0);
    cpl_ready = 1'b1;
    applyStimulus("t7.new", 4'd6, AXI_RESP_OKAY, 1'b1, 1'b1, 4'd0);
    expectCpl("t7", mkCpl(1'b0, 4'd6, 2'b00, 1'b0, 1));
    tick();
    checkOutput("t7.drain", 64'(cpl_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
